// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Writable program memory filled from a framed byte stream
//                (length, data, checksum); holds the CPU in reset until the
//                frame verifies. Combinational CPU read port.
//  Revision    : 1.0  initial release
// ============================================================================
module program_loader #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_enable_n,
   output logic [DATA_W-1:0] cpu_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CHK  = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_remain;
   logic [DATA_W-1:0] r_checksum;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_xfer;
   logic              w_start_ok;
   logic              w_len_bad;
   logic [ADDR_W:0]   w_len;

   assign in_ready = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
   assign cpu_hold = in_ready || (r_state == S_ERR);
   assign done     = (r_state == S_DONE);
   assign error    = (r_state == S_ERR);
   assign checksum = r_checksum;

   assign w_xfer     = in_valid && in_ready;
   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
   assign w_len_bad  = (in_data[DATA_W-1:ADDR_W] != '0);
   // A zero length field encodes a full-depth frame.
   assign w_len      = (in_data[ADDR_W-1:0] == '0) ? c_depth : {1'b0, in_data[ADDR_W-1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) w_next = S_LEN;
         end
         S_LEN: begin
            if (w_xfer) w_next = w_len_bad ? S_ERR : S_DATA;
         end
         S_DATA: begin
            if (w_xfer && (r_remain == c_one)) w_next = S_CHK;
         end
         S_CHK: begin
            if (w_xfer) w_next = (in_data == r_checksum) ? S_DONE : S_ERR;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr     <= '0;
         r_remain   <= '0;
         r_checksum <= '0;
      end else if (w_start_ok) begin
         r_addr     <= '0;
         r_remain   <= '0;
         r_checksum <= '0;
      end else if (w_xfer) begin
         if (r_state == S_LEN) begin
            r_remain <= w_len;
         end else if (r_state == S_DATA) begin
            r_addr     <= r_addr + 1'b1;
            r_remain   <= r_remain - c_one;
            r_checksum <= r_checksum + in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_xfer && (r_state == S_DATA)) begin
         r_mem[r_addr] <= in_data;
      end
   end

   // Read is combinational from the array, so a same-cycle write is seen only after the edge.
   assign cpu_data = cpu_enable_n ? '0 : r_mem[cpu_addr];

endmodule
`default_nettype wire
